fifo_wr_arbiter: RTL and testbench

- Shares the write port of one fifo instance between R producers using round-robin arbitration with bounded bursts.
- Each producer has a valid/ready channel; the block drives the fifo's write, din and consumes its full flag.
- Sits directly in front of fifo; the fifo read side is untouched.

---
 rtl/fifo_wr_arb_pkg.sv | 28 ++
 rtl/fifo_wr_arbiter_if.sv | 48 ++++
 rtl/fifo_wr_arbiter_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// ============================================================================
// Module      : fifo_wr_arb_pkg
// Description : Shared types, constants and helpers for the fifo write-port
//               round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_wr_arb_pkg;

  // Arbiter FSM states: IDLE picks the next owner, BUSY forwards its writes.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Width of each per-requester transfer statistics counter.
  localparam int STAT_W = 16;

  // Folds an index in [0, 2n) back into [0, n); used for round-robin wrap
  // so that no index ever reaches n, even when n is not a power of two.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Bundles the requester valid/ready channels, the fifo write
//               port and the grant status of the fifo write arbiter.
//               slave  = arbiter side, master = requesters/fifo side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wr_arbiter_if #(
  parameter int R = 4,
  parameter int M = 16
);

  logic [R-1:0]           req_valid;
  logic [R-1:0][M-1:0]    req_data;
  logic [R-1:0]           req_ready;
  logic                   fifo_write;
  logic [M-1:0]           fifo_din;
  logic                   fifo_full;
  logic                   grant_vld;
  logic [$clog2(R)-1:0]   grant_id;

  modport slave (
    input  req_valid,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_write,
    output fifo_din,
    output grant_vld,
    output grant_id
  );

  modport master (
    output req_valid,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_write,
    input  fifo_din,
    input  grant_vld,
    input  grant_id
  );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req searching ptr, ptr+1, ... with wrap at R-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int R = 4
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(R)-1:0] idx
);

  localparam int c_idw = $clog2(R);

  // Walk from the farthest slot back to ptr so the nearest set bit wins.
  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = R - 1; k >= 0; k--) begin
      j = rr_wrap(int'(ptr) + k, R);
      if (req[j]) begin
        any = 1'b1;
        idx = c_idw'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Shares one fifo write port between R producers using
//               round-robin arbitration with bursts of at most MAX_BURST
//               writes per grant. Grants are registered (one idle bubble
//               between owners); the fifo never sees write while full.
//               Optional build macro FIFO_WR_ARB_STATS_EN adds saturating
//               per-requester transfer counters (stat_cnt) with clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int R         = 4,
  parameter int M         = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  fifo_wr_arbiter_if.slave             bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [R-1:0][STAT_W-1:0]     stat_cnt
`endif
);

  localparam int              c_idw       = $clog2(R);
  localparam int              c_cw        = $clog2(MAX_BURST + 1);
  localparam logic [c_cw-1:0] c_last_beat = c_cw'(MAX_BURST - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [c_idw-1:0]   r_owner;
  logic [c_idw-1:0]   w_owner_nxt;
  logic [c_idw-1:0]   r_ptr;
  logic [c_idw-1:0]   w_ptr_nxt;
  logic [c_cw-1:0]    r_cnt;
  logic [c_cw-1:0]    w_cnt_nxt;

  logic               w_any;
  logic [c_idw-1:0]   w_pick;
  logic               w_owner_valid;
  logic               w_xfer;
  logic [c_idw-1:0]   w_owner_inc;

  rr_pick #(
    .R (R)
  ) u_rr_pick (
    .req (bus.req_valid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_xfer        = (r_state == ARB_BUSY) && w_owner_valid && !bus.fifo_full;
  assign w_owner_inc   = c_idw'(rr_wrap(int'(r_owner) + 1, R));

  // Arbiter state registers; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: pick in IDLE; in BUSY count writes, stall on full, release on
  // owner drop or last beat of the burst.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_BUSY;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      ARB_BUSY: begin
        if (!w_owner_valid) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = w_owner_inc;
          w_cnt_nxt   = '0;
        end else if (!bus.fifo_full) begin
          if (r_cnt == c_last_beat) begin
            w_state_nxt = ARB_IDLE;
            w_ptr_nxt   = w_owner_inc;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_cw'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Output mux: everything is zero in IDLE; BUSY exposes the owner's channel.
  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_write = 1'b0;
    bus.fifo_din   = '0;
    bus.grant_vld  = 1'b0;
    bus.grant_id   = '0;
    if (r_state == ARB_BUSY) begin
      bus.grant_vld           = 1'b1;
      bus.grant_id            = r_owner;
      bus.req_ready[r_owner]  = !bus.fifo_full;
      bus.fifo_din            = bus.req_data[r_owner];
      bus.fifo_write          = w_xfer;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [R-1:0][STAT_W-1:0] r_stat;

  for (genvar gi = 0; gi < R; gi++) begin : g_stat
    // Saturating transfer counter for requester gi; clear beats increment.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_stat[gi] <= '0;
      end else if (stat_clr) begin
        r_stat[gi] <= '0;
      end else if (w_xfer && (r_owner == c_idw'(gi)) && (r_stat[gi] != {STAT_W{1'b1}})) begin
        r_stat[gi] <= r_stat[gi] + STAT_W'(1);
      end
    end
  end

  assign stat_cnt = r_stat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter: directed scenarios
//               plus random traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;
  import fifo_wr_arb_pkg::*;

  localparam int R  = 4;
  localparam int M  = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.R(R), .M(M)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic                     stat_clr;
  logic [R-1:0][STAT_W-1:0] stat_cnt;
`endif

  fifo_wr_arbiter #(
    .R         (R),
    .M         (M),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: who holds the port, where the next search starts,
  // how many writes the current holder has already made.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_used;

  // Observations of the last stepped cycle (stimulus bookkeeping only).
  logic [R-1:0]         obs_rdy;
  logic                 obs_wr;
  logic                 obs_gv;
  logic [$clog2(R)-1:0] obs_gid;
  logic [R-1:0]         last_xfer;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_used  = 0;
  endtask

  task automatic model_release();
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % R;
    m_used = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model
  // with the inputs the DUT will sample at the coming edge.
  task automatic step();
    logic [R-1:0] e_rdy;
    logic         e_wr;
    logic [M-1:0] e_din;
    bit           found;
    int           j;
    @(negedge clk);
    e_rdy = '0;
    e_wr  = 1'b0;
    e_din = '0;
    if (m_busy) begin
      if (!bus.fifo_full) e_rdy[m_owner] = 1'b1;
      e_wr  = bus.req_valid[m_owner] && !bus.fifo_full;
      e_din = bus.req_data[m_owner];
    end
    check("req_ready",  bus.req_ready,  e_rdy);
    check("fifo_write", bus.fifo_write, e_wr);
    check("fifo_din",   bus.fifo_din,   e_din);
    check("grant_vld",  bus.grant_vld,  m_busy);
    check("grant_id",   bus.grant_id,   m_busy ? m_owner : 0);
    check("ready_onehot0", $onehot0(bus.req_ready), 1'b1);
    check("no_write_when_full", bus.fifo_write && bus.fifo_full, 1'b0);
    obs_rdy   = bus.req_ready;
    obs_wr    = bus.fifo_write;
    obs_gv    = bus.grant_vld;
    obs_gid   = bus.grant_id;
    last_xfer = bus.req_valid & bus.req_ready;
    if (!rst) begin
      model_reset();
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < R; k++) begin
        j = (m_ptr + k) % R;
        if (!found && bus.req_valid[j]) begin
          found   = 1'b1;
          m_owner = j;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_used = 0;
      end
    end else if (!bus.req_valid[m_owner]) begin
      model_release();
    end else if (!bus.fifo_full) begin
      m_used++;
      if (m_used == MB) model_release();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  int          k;
  int          nwr;
  int          gq[$];
  int          wr_by[R];
  logic        prev_gv;
  bit          hit;

  initial begin
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.fifo_full  = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr       = 1'b0;
`endif
    @(posedge clk);
    #1;
    model_reset();

    // Reset state: all outputs zero.
    step();
    check("reset_gv",  obs_gv,  1'b0);
    check("reset_rdy", obs_rdy, '0);
    rst = 1'b1;

    // Single requester 1, incrementing data, fifo never full.
    k = 0;
    bus.req_valid = 4'b0010;
    bus.req_data[1] = 16'h0A00;
    repeat (20) begin
      step();
      if (last_xfer[1]) begin
        k++;
        bus.req_data[1] = M'(16'h0A00 + k);
      end
    end
    check("single_req_writes", k, 16);

    // All four requesters continuously valid: grant order 0,1,2,3,0.
    bus.req_valid = '0;
    pulse_reset();
    bus.req_valid = 4'b1111;
    gq.delete();
    foreach (wr_by[i]) wr_by[i] = 0;
    prev_gv = 1'b0;
    for (int c = 0; c < 26; c++) begin
      for (int i = 0; i < R; i++) bus.req_data[i] = M'($urandom);
      step();
      if (obs_gv && !prev_gv) gq.push_back(int'(obs_gid));
      if (obs_wr && c < 21) wr_by[obs_gid]++;
      prev_gv = obs_gv;
    end
    check("rr_grant_count", gq.size(), 5);
    for (int i = 0; i < gq.size(); i++) check("rr_grant_order", gq[i], i % R);
    for (int i = 0; i < R; i++) check("rr_burst_len", wr_by[i], MB);

    // Full for 3 cycles mid-burst of requester 3.
    bus.req_valid = '0;
    pulse_reset();
    bus.req_valid = 4'b1000;
    nwr = 0;
    repeat (3) begin step(); nwr += int'(obs_wr); end
    bus.fifo_full = 1'b1;
    repeat (3) begin step(); check("stall_no_write", obs_wr, 1'b0); nwr += int'(obs_wr); end
    bus.fifo_full = 1'b0;
    repeat (2) begin step(); nwr += int'(obs_wr); end
    step();
    check("stall_burst_total", nwr, MB);
    check("stall_release_idle", obs_gv, 1'b0);

    // Requester 0 drops after 2 writes while requester 1 waits.
    bus.req_valid = '0;
    pulse_reset();
    bus.req_valid = 4'b0011;
    repeat (3) step();
    bus.req_valid = 4'b0010;
    step();
    check("drop_no_write", obs_wr, 1'b0);
    step();
    check("drop_bubble", obs_gv, 1'b0);
    step();
    check("drop_next_gv", obs_gv, 1'b1);
    check("drop_next_id", obs_gid, 1);

    // Reset mid-burst of owner 2, re-arbitration starts from 0.
    bus.req_valid = '0;
    pulse_reset();
    bus.req_valid = 4'b1111;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      step();
      hit = obs_wr && (obs_gid == 2);
    end
    check("midburst_reached_owner2", hit, 1'b1);
    pulse_reset();
    step();
    check("midburst_rst_gv",  obs_gv,  1'b0);
    check("midburst_rst_rdy", obs_rdy, '0);
    check("midburst_rst_wr",  obs_wr,  1'b0);
    step();
    check("midburst_regrant_id", obs_gid, 0);

`ifdef FIFO_WR_ARB_STATS_EN
    // Statistics: 10 transfers from requester 2, then clear.
    bus.req_valid = '0;
    pulse_reset();
    bus.req_valid = 4'b0100;
    k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      step();
      if (last_xfer[2]) k++;
      if (k == 10) bus.req_valid = '0;
    end
    step();
    check("stat_cnt2", stat_cnt[2], 10);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    step();
    check("stat_clr", stat_cnt[2], 0);
`endif

    // Random traffic with occasional reset.
    for (int c = 0; c < 800; c++) begin
      bus.req_valid = R'($urandom);
      bus.fifo_full = ($urandom % 4) == 0;
      for (int i = 0; i < R; i++) bus.req_data[i] = M'($urandom);
      rst = ($urandom % 64) != 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
